sign_bit_normalizer: RTL and testbench

Pipelined normalization controller that sits directly upstream of the arithmetic left barrel shifter. Each accepted signed word has its redundant sign bits counted. The block then registers the word together with the shift amount that normalizes it, so the shifter can consume them without further logic: normalized = data_o <<< shifts_o. Input and output both use a valid/ready handshake with a single registered stage, and the block sustains one word per clock.

---
 rtl/sign_bit_normalizer.sv | 106 ++++++++++
 tb/tb_sign_bit_normalizer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sign_bit_normalizer.sv
// Sign-bit normalization stage: counts redundant sign bits of each accepted word
// and registers the word with its clamped left-shift amount.
// Optional zero flag output enabled by defining SIGN_NORM_ZERO_EN.
module sign_bit_normalizer #(
  parameter int unsigned DATA_WIDTH  = 22,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned MAX_SHIFT   = 21
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
`ifdef SIGN_NORM_ZERO_EN
  output logic                   zero_o,
`endif
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic [SHIFT_WIDTH-1:0] shifts_o
);

  localparam int unsigned CNT_W = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH);

  // Elaboration-time parameter sanity checks
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("sign_bit_normalizer: DATA_WIDTH must be at least 2");
  end
  if (MAX_SHIFT < 1 || MAX_SHIFT > DATA_WIDTH - 1) begin : g_bad_max
    $error("sign_bit_normalizer: MAX_SHIFT out of range");
  end
  if ((2 ** SHIFT_WIDTH) - 1 < MAX_SHIFT) begin : g_bad_shift_w
    $error("sign_bit_normalizer: SHIFT_WIDTH too narrow for MAX_SHIFT");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       rsc_c;
  logic                   run_c;
  logic [SHIFT_WIDTH-1:0] shift_c;
  logic                   in_xfer_c;
  logic                   out_xfer_c;

  // Count bits below the sign bit that match it, stopping at the first mismatch
  always_comb begin
    rsc_c = '0;
    run_c = 1'b1;
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      if (run_c && (data_i[i] == data_i[DATA_WIDTH-1])) begin
        rsc_c = rsc_c + CNT_W'(1);
      end else begin
        run_c = 1'b0;
      end
    end
  end

  always_comb begin
    shift_c = SHIFT_WIDTH'(rsc_c);
    if (32'(rsc_c) > MAX_SHIFT) begin
      shift_c = SHIFT_WIDTH'(MAX_SHIFT);
    end
  end

  assign valid_o    = (state == FULL);
  assign ready_o    = ~valid_o | ready_i;
  assign in_xfer_c  = valid_i & ready_o;
  assign out_xfer_c = valid_o & ready_i;

  // Single output register: load on input transfer, drain on output transfer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= EMPTY;
      data_o   <= '0;
      shifts_o <= '0;
`ifdef SIGN_NORM_ZERO_EN
      zero_o   <= 1'b0;
`endif
    end else begin
      if (in_xfer_c) begin
        data_o   <= data_i;
        shifts_o <= shift_c;
`ifdef SIGN_NORM_ZERO_EN
        zero_o   <= (data_i == '0);
`endif
      end
      case (state)
        EMPTY: begin
          if (in_xfer_c) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (out_xfer_c && !in_xfer_c) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_bit_normalizer.sv
// Self-checking bench for sign_bit_normalizer: directed table, back-pressure,
// streaming scoreboard and async reset; a second instance uses MAX_SHIFT=8.
module tb_sign_bit_normalizer;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_i;
  logic [21:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [21:0] data_o;
  logic [4:0]  shifts_o;
  logic        ready8;
  logic        valid8;
  logic [21:0] data8;
  logic [4:0]  shifts8;
`ifdef SIGN_NORM_ZERO_EN
  logic        zero_o;
  logic        zero8;
`endif

  int total = 0;
  int bad   = 0;

  sign_bit_normalizer dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
`ifdef SIGN_NORM_ZERO_EN
    .zero_o(zero_o),
`endif
    .data_o(data_o), .shifts_o(shifts_o)
  );

  sign_bit_normalizer #(.DATA_WIDTH(22), .SHIFT_WIDTH(5), .MAX_SHIFT(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready8),
    .data_i(data_i), .valid_o(valid8), .ready_i(ready_i),
`ifdef SIGN_NORM_ZERO_EN
    .zero_o(zero8),
`endif
    .data_o(data8), .shifts_o(shifts8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] data;
    logic [4:0]  sh;
    logic [4:0]  sh8;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position of the highest bit differing from the sign bit
  function automatic logic [4:0] ref_rsc(input logic [21:0] d);
    int hi;
    hi = -1;
    for (int k = 0; k <= 20; k++) if (d[k] != d[21]) hi = k;
    return (hi < 0) ? 5'd21 : 5'(20 - hi);
  endfunction

  function automatic logic [4:0] clamp8(input logic [4:0] s);
    return (s > 5'd8) ? 5'd8 : s;
  endfunction

  task automatic send_one(input logic [21:0] d, input logic [4:0] e, input logic [4:0] e8);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = d;
    ready_i = 1'b1;
    #1 chk("ready_before_accept", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    chk("valid_after_accept", 32'(valid_o), 32'd1);
    chk("data_o", 32'(data_o), 32'(d));
    chk("shifts_o", 32'(shifts_o), 32'(e));
    chk("shifts_o_max8", 32'(shifts8), 32'(e8));
  endtask

  vec_t        vecs[12];
  logic [21:0] q[$];
  logic [21:0] exp_d;
  int          sent;
  int          recv;
  int          max_depth;

  initial begin
    vecs[0]  = '{22'h000001, 5'd20, 5'd8};
    vecs[1]  = '{22'h3FFFFF, 5'd21, 5'd8};
    vecs[2]  = '{22'h200000, 5'd0,  5'd0};
    vecs[3]  = '{22'h0FFFFF, 5'd1,  5'd1};
    vecs[4]  = '{22'h3C0000, 5'd3,  5'd3};
    vecs[5]  = '{22'h000100, 5'd12, 5'd8};
    vecs[6]  = '{22'h001000, 5'd8,  5'd8};
    vecs[7]  = '{22'h000010, 5'd16, 5'd8};
    vecs[8]  = '{22'h000002, 5'd19, 5'd8};
    vecs[9]  = '{22'h000000, 5'd21, 5'd8};
    vecs[10] = '{22'h155555, 5'd0,  5'd0};
    vecs[11] = '{22'h3FFFFE, 5'd20, 5'd8};

    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    #12;
    chk("reset_valid_o", 32'(valid_o), 32'd0);
    chk("reset_data_o", 32'(data_o), 32'd0);
    chk("reset_shifts_o", 32'(shifts_o), 32'd0);
    chk("reset_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, one word at a time
    for (int i = 0; i < 12; i++) send_one(vecs[i].data, vecs[i].sh, vecs[i].sh8);
    @(negedge clk);
    chk("drained_valid_o", 32'(valid_o), 32'd0);

    // Back-pressure: first word loads into the empty register, later words stall
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 22'h000010;
    @(negedge clk);
    data_i = 22'h000020;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_valid_o", 32'(valid_o), 32'd1);
      chk("bp_data_o", 32'(data_o), 32'h000010);
      chk("bp_shifts_o", 32'(shifts_o), 32'd16);
      chk("bp_ready_o", 32'(ready_o), 32'd0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    #1 chk("bp_release_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(valid_o), 32'd1);
    chk("bp_next_data", 32'(data_o), 32'h000020);
    chk("bp_next_shifts", 32'(shifts_o), 32'd15);
    @(negedge clk);
    chk("bp_empty_after", 32'(valid_o), 32'd0);

    // Streaming: full rate, then randomized handshakes, scoreboarded
    sent = 0;
    recv = 0;
    max_depth = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c < 100) begin
        valid_i = 1'b1;
        ready_i = 1'b1;
      end else if (c < 380) begin
        valid_i = 1'($urandom_range(0, 1));
        ready_i = 1'($urandom_range(0, 3) != 0);
      end else begin
        valid_i = 1'b0;
        ready_i = 1'b1;
      end
      data_i = 22'($urandom);
      if (c % 7 == 0) data_i = 22'($urandom) >> $urandom_range(0, 21);
      #1;
      chk("stream_ready_o", 32'(ready_o), 32'(!valid_o || ready_i));
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_output", 32'(valid_o), 32'd0);
        end else begin
          exp_d = q.pop_front();
          recv++;
          chk("stream_data_o", 32'(data_o), 32'(exp_d));
          chk("stream_shifts_o", 32'(shifts_o), 32'(ref_rsc(exp_d)));
          chk("stream_shifts8", 32'(shifts8), 32'(clamp8(ref_rsc(exp_d))));
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(data_i);
        sent++;
      end
      if (c < 100 && q.size() > max_depth) max_depth = q.size();
    end
    chk("stream_count", 32'(recv), 32'(sent));
    chk("stream_leftover", 32'(q.size()), 32'd0);
    chk("stream_fullrate_depth", 32'(max_depth), 32'd1);
    chk("stream_min_words", 32'(sent >= 100), 32'd1);

    // Async reset while FULL, asserted between edges
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 22'h000040;
    @(posedge clk);
    #1 valid_i = 1'b0;
    #2;
    chk("pre_reset_full", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_o", 32'(valid_o), 32'd0);
    chk("async_rst_data_o", 32'(data_o), 32'd0);
    chk("async_rst_shifts_o", 32'(shifts_o), 32'd0);
    chk("async_rst_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", 32'(valid_o), 32'd0);
    send_one(22'h000002, 5'd19, 5'd8);

`ifdef SIGN_NORM_ZERO_EN
    send_one(22'h000000, 5'd21, 5'd8);
    chk("zero_o_for_zero", 32'(zero_o), 32'd1);
    send_one(22'h3FFFFF, 5'd21, 5'd8);
    chk("zero_o_for_minus1", 32'(zero_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
